// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave data-phase state type.
package ahb_pkg;

  localparam int unsigned HDATA_W    = 32;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER,
    S_ERR1,
    S_ERR2
  } sram_state_t;

endpackage

// File: rtl/ahb_wait_counter.sv
// Loadable down-counter with a registered zero flag; holds at zero.
module ahb_wait_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count != '0)) begin
      count_d = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else begin
      count <= count_d;
      zero  <= (count_d == '0);
    end
  end

endmodule

// File: rtl/ahb_wait_sram.sv
// AHB-Lite word SRAM slave with programmable wait states.
// Define AHB_SRAM_ERR_EN to enable ERROR responses for out-of-range or unaligned accesses.
module ahb_wait_sram
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic               HREADYIN,
  input  logic [HDATA_W-1:0] HWDATA,
  output logic [HDATA_W-1:0] HRDATA,
  output logic               HREADYOUT,
  output logic [1:0]         HRESP
);

  localparam int unsigned WORD_W    = ADDR_W - 2;
  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  sram_state_t            state_q, state_d;
  logic [HDATA_W-1:0]     mem [MEM_DEPTH];
  logic [WORD_W-1:0]      word_c;
  logic [IDX_W-1:0]       idx_c, idx_q, idx_d;
  logic                   wr_q, wr_d;
  logic                   accept_c, err_c;
  logic                   cnt_load, cnt_dec, cnt_zero;
  logic [WAIT_CNT_W-1:0]  cnt_count;
  logic [HDATA_W-1:0]     rd_word_c;
  logic                   unused_c;

  assign word_c   = HADDR[ADDR_W-1:2];
  assign idx_c    = IDX_W'(32'(word_c) % MEM_DEPTH);
  assign accept_c = HSEL & HREADYIN & HREADYOUT & HTRANS[1];

`ifdef AHB_SRAM_ERR_EN
  assign err_c = (32'(word_c) >= MEM_DEPTH) || (HADDR[1:0] != 2'b00);
`else
  assign err_c = 1'b0;
`endif

  assign unused_c = ^{HSIZE, HADDR[31:ADDR_W], HADDR[1:0], HTRANS[0], cnt_count};

  ahb_wait_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (cnt_load),
    .load_val (WAIT_CNT_W'(WAIT_LOAD)),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Data-phase sequencing; a new access can start whenever HREADYOUT is high.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE, S_XFER, S_ERR2: begin
        state_d = S_IDLE;
        if (accept_c) begin
          if (err_c) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d  = S_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          state_d = S_XFER;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  assign idx_d = accept_c ? idx_c : idx_q;
  assign wr_d  = accept_c ? HWRITE : wr_q;

  // Forward a write committing this cycle so back-to-back read-after-write sees new data.
  always_comb begin
    rd_word_c = mem[idx_d];
    if ((state_q == S_XFER) && wr_q && (idx_q == idx_d)) begin
      rd_word_c = HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wr_q      <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= OKAY;
      HRDATA    <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        idx_q <= idx_c;
        wr_q  <= HWRITE;
      end
      HREADYOUT <= (state_d == S_IDLE) || (state_d == S_XFER) || (state_d == S_ERR2);
      HRESP     <= ((state_d == S_ERR1) || (state_d == S_ERR2)) ? ERROR : OKAY;
      HRDATA    <= ((state_d == S_XFER) && !wr_d) ? rd_word_c : '0;
    end
  end

  // Memory contents survive reset; a write in flight during reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_XFER) && wr_q) begin
      mem[idx_q] <= HWDATA;
    end
  end

endmodule

// File: doc/ahb_wait_sram.md
# ahb_wait_sram

AHB-Lite word-addressed SRAM slave with a programmable number of wait states, sitting directly downstream of the DMAC master port. It consumes `MAddress/MTrans/MWrite/MWData` as `HADDR/HTRANS/HWRITE/HWDATA` and returns `HRDATA/HREADYOUT/HRESP`. It is the source/destination memory model for DMAC throughput and back-pressure verification, and is synthesizable as a scratch RAM.

## Interface
- `MEM_DEPTH`, 256: number of 32-bit words.
- `WAIT_STATES`, 0: `HREADYOUT`-low cycles inserted in every OKAY data phase (0..15).
- `ADDR_W`, 12: decoded region size in address bits (4 KB window). Upper `HADDR` bits are ignored.
- `HCLK` in 1: clock, rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HADDR` in 32: byte address.
- `HTRANS` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `HWRITE` in 1: 1 = write.
- `HSIZE` in 3: ignored; all transfers are 32-bit.
- `HREADYIN` in 1: bus ready from the interconnect.
- `HWDATA` in 32: write data, valid in the data phase.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: data phase complete.
- `HRESP` out 2: 00 OKAY, 01 ERROR.

## Operation
- An address phase is accepted when `HSEL & HREADYIN & HREADYOUT & HTRANS[1]`. On acceptance the slave registers the word index `HADDR[ADDR_W-1:2]`, `HWRITE`, and an error flag.
- IDLE or BUSY transfers, or `HSEL`=0, create no data phase. The response is zero-wait OKAY.
- Data-phase FSM states: `IDLE`, `WAIT`, `XFER`, `ERR1`, `ERR2`.
  - `IDLE`, accepted access, no error: go to `WAIT` if `WAIT_STATES`>0, else `XFER`.
  - `WAIT`: count down from `WAIT_STATES`, then go to `XFER`.
  - `XFER` is one cycle with `HREADYOUT`=1. A read drives `HRDATA=mem[idx]`. A write commits `mem[idx]<=HWDATA` at the end of the cycle.
  - From `XFER`, a newly accepted access restarts the sequence back-to-back; otherwise go to `IDLE`.
  - Accepted access with error: `ERR1` (`HREADYOUT`=0, `HRESP`=01), then `ERR2` (`HREADYOUT`=1, `HRESP`=01). No wait states are inserted and no memory write occurs.
- `HRDATA` is 0 in every cycle other than a read `XFER`.
- Read-after-write to the same word in consecutive transfers returns the new data, because the write commits before the next data phase.
- Address phases presented while `HREADYOUT`=0 are ignored. The master must hold them per the AHB protocol.
- Memory contents are not affected by reset.

## Timing
- Reset values: `HREADYOUT`=1, `HRESP`=00, `HRDATA`=0, FSM=`IDLE`, wait counter=0.
- With `WAIT_STATES`=N, a transfer accepted at edge k has `HREADYOUT` low for cycles k+1..k+N and high at k+N+1.
- Sustained throughput is one word per N+1 cycles. With N=0 it is one word per cycle, fully pipelined.
- ERROR responses always take exactly 2 cycles.
- A reset asserted mid-data-phase aborts the transfer; a pending write is dropped. The next cycle shows the reset values.

## Configuration
- `AHB_SRAM_ERR_EN` defined: an accepted access raises ERROR when the word index is ≥ `MEM_DEPTH` or when `HADDR[1:0]`≠0.
- Not defined: the ERROR path is absent and `HRESP` is constant 00. The index wraps modulo `MEM_DEPTH`, and `HADDR[1:0]` is ignored.

## Structure
- Shared package `ahb_pkg`:
  - `htrans_t` with values IDLE/BUSY/NONSEQ/SEQ.
  - `hresp_t` with values OKAY/ERROR.
  - The FSM state enum `sram_state_t`.
- One sub-module: `ahb_wait_counter`, a loadable down-counter with a `zero` flag. The memory array and FSM stay in the top.

## Test plan
1. Reset values: assert `HRESET` for 3 cycles → `HREADYOUT`=1, `HRESP`=00, `HRDATA`=0.
2. Zero-wait burst:
   - `WAIT_STATES`=0. Write 0xAABBCCDD, 0x11223344 to 0x0, 0x4 (NONSEQ, SEQ), then read both back.
   - → `HREADYOUT` never low, read data matches, 4 transfers in 4 data cycles.
3. Wait states: `WAIT_STATES`=2, single read of 0x8 holding 0x55667788 → `HREADYOUT` low exactly 2 cycles, then high with `HRDATA`=0x55667788.
4. Error path, `AHB_SRAM_ERR_EN` defined, `MEM_DEPTH`=256:
   - Write 0xDEAD to 0x400 → `HRESP`=01 for 2 cycles, `HREADYOUT` 0 then 1, and `mem[0]` is unchanged.
   - Without the macro, the same write lands in `mem[0]`.
5. DMAC integration:
   - Dmac_Top moves 18 words from a source instance to a destination instance, both with `WAIT_STATES`=1.
   - → all 18 destination words equal the source words, and `Interrupt` asserts.
6. Reset mid-write: assert `HRESET` during a `WAIT` cycle of a write to 0xC → `mem[3]` is unchanged and outputs show the reset values on the next cycle.
